seg7_display_ctrl: RTL and testbench

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

---
 rtl/seg7_display_ctrl.sv | 134 +++++++++++++
 tb/tb_seg7_display_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Hex seven-segment display controller: shadowed value/dp, leading-zero blanking,
// 16-step PWM dimming, and either static per-digit or time-multiplexed scan outputs.
module seg7_display_ctrl #(
    parameter int DIGITS     = 4,
    parameter int MULTIPLEX  = 0,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [8*DIGITS-1:0]   seg,
    output logic [7:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_en
);

    localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_TC = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);
    localparam logic           INV      = (ACTIVE_LOW != 0);

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp;
    logic [3:0]          r_pwm;
    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [8*DIGITS-1:0] r_seg;
    logic [7:0]          r_scan_seg;
    logic [DIGITS-1:0]   r_scan_en;

    logic                w_active;
    logic                w_tc;
    logic [8*DIGITS-1:0] w_pat;
    logic [7:0]          w_cur_pat;
    logic [DIGITS-1:0]   w_cur_en;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_dp    <= '0;
        end else if (load) begin
            r_value <= value;
            r_dp    <= dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_pwm <= '0;
        else       r_pwm <= r_pwm + 4'd1;
    end

    assign w_active = (r_pwm < brightness);
    assign w_tc     = (r_presc == PRESC_TC);

    // Walk from the most significant digit down; a digit blanks only while the
    // run of zeros from the top is unbroken, and digit 0 always shows.
    always_comb begin : pat_build
        logic v_lz_run;
        w_pat    = '0;
        v_lz_run = blank_lz;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v_lz_run = v_lz_run && (r_value[4*d +: 4] == 4'h0);
            if (v_lz_run && (d != 0)) w_pat[8*d +: 8] = 8'h00;
            else                      w_pat[8*d +: 8] = {r_dp[d], f_decode(r_value[4*d +: 4])};
        end
    end

    always_comb begin
        w_cur_pat = '0;
        w_cur_en  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == r_idx) begin
                w_cur_pat   = w_pat[8*d +: 8];
                w_cur_en[d] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_seg <= '0;
        else       r_seg <= (MULTIPLEX == 0 && w_active) ? w_pat : '0;
    end

    // The terminal-count cycle doubles as the inter-digit dead time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_scan_seg <= '0;
            r_scan_en  <= '0;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            if (MULTIPLEX != 0 && !w_tc && w_active) begin
                r_scan_seg <= w_cur_pat;
                r_scan_en  <= w_cur_en;
            end else begin
                r_scan_seg <= '0;
                r_scan_en  <= '0;
            end
        end
    end

    assign seg      = (reset ? '0 : r_seg)      ^ {(8*DIGITS){INV}};
    assign scan_seg = (reset ? '0 : r_scan_seg) ^ {8{INV}};
    assign scan_en  = (reset ? '0 : r_scan_en)  ^ {DIGITS{INV}};

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: one static-mode and one scan-mode instance
// sharing stimulus, with hand-computed active-low patterns.
module tb_seg7_display_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [3:0]  brightness;

    logic [31:0] seg_s, seg_m;
    logic [7:0]  scan_seg_s, scan_seg_m;
    logic [3:0]  scan_en_s, scan_en_m;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] m_pwm;
    logic [3:0] pwm_used;
    logic       act;

    localparam logic [31:0] P_ZERO = 32'hC0C0C0C0;
    localparam logic [31:0] P_12AF = 32'hF9A4888E;
    localparam logic [31:0] P_0050 = 32'hC0C092C0;
    localparam logic [31:0] OFF32  = 32'hFFFFFFFF;

    logic [3:0] en_tab  [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [7:0] sseg_tab[16] = '{8'h8E, 8'h8E, 8'h8E, 8'hFF, 8'h88, 8'h88, 8'h88, 8'hFF,
                                 8'hA4, 8'hA4, 8'hA4, 8'hFF, 8'hF9, 8'hF9, 8'hF9, 8'hFF};

    seg7_display_ctrl #(.DIGITS(4), .MULTIPLEX(0), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_static (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg_s), .scan_seg(scan_seg_s), .scan_en(scan_en_s)
    );

    seg7_display_ctrl #(.DIGITS(4), .MULTIPLEX(1), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_scan (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg_m), .scan_seg(scan_seg_m), .scan_en(scan_en_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, track the PWM phase the DUT used at that edge, settle.
    task automatic tick();
        @(posedge clk);
        pwm_used = m_pwm;
        act      = !reset && (pwm_used < brightness);
        m_pwm    = reset ? 4'd0 : m_pwm + 4'd1;
        #1;
    endtask

    function automatic logic [31:0] gate(input logic [31:0] p);
        return act ? p : OFF32;
    endfunction

    initial begin
        int cnt;
        int bvals [4] = '{0, 1, 8, 15};
        logic [31:0] prev_pat, cur_pat;

        reset = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0;
        blank_lz = 1'b0; brightness = 4'd15; m_pwm = 4'd0; act = 1'b0;

        tick(); tick();
        chk("rst_seg", seg_s, OFF32);
        chk("rst_scan_en", {28'h0, scan_en_m}, 32'hF);
        chk("rst_scan_seg", {24'h0, scan_seg_m}, 32'hFF);

        // load during reset must be ignored
        load = 1'b1; value = 16'h12AF;
        tick();
        reset = 1'b0; load = 1'b0;
        tick();
        chk("post_rst", seg_s, gate(P_ZERO));
        tick();
        chk("load_ignored", seg_s, gate(P_ZERO));
        chk("static_scan_en_off", {28'h0, scan_en_s}, 32'hF);
        chk("static_scan_seg_off", {24'h0, scan_seg_s}, 32'hFF);

        value = 16'h12AF; load = 1'b1;
        tick();
        load = 1'b0;
        chk("lat_n1_old", seg_s, gate(P_ZERO));
        tick();
        chk("lat_n2_new", seg_s, gate(P_12AF));

        value = 16'h0050; blank_lz = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("blank_0050", seg_s, gate(32'hFFFF92C0));
        blank_lz = 1'b0;
        tick();
        chk("blank_off_noreload", seg_s, gate(P_0050));
        blank_lz = 1'b1; value = 16'h0000; dp = 4'b0011; load = 1'b1;
        tick();
        load = 1'b0; dp = 4'b0000;
        tick();
        chk("blank_zero_dp", seg_s, gate(32'hFFFFFF40));

        value = 16'h12AF; blank_lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        foreach (bvals[i]) begin
            brightness = 4'(bvals[i]);
            cnt = 0;
            repeat (16) begin
                tick();
                if (seg_s !== OFF32) cnt++;
            end
            chk($sformatf("bright_%0d", bvals[i]), 32'(cnt), 32'(bvals[i]));
        end
        brightness = 4'd15;

        // load held high, value toggles every cycle
        load = 1'b1;
        prev_pat = P_12AF;
        for (int i = 0; i < 8; i++) begin
            value   = (i % 2 == 1) ? 16'h0050 : 16'h12AF;
            cur_pat = (i % 2 == 1) ? P_0050 : P_12AF;
            tick();
            if (i >= 1) chk($sformatf("follow_%0d", i), seg_s, gate(prev_pat));
            prev_pat = cur_pat;
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            value = (i % 2 == 0) ? 16'hFFFF : 16'h1234;
            tick();
            chk($sformatf("frozen_%0d", i), seg_s, gate(P_0050));
        end

        // scan mode: reset, then release with load high so digit data arrives a cycle later
        reset = 1'b1; load = 1'b1; value = 16'h12AF; blank_lz = 1'b0;
        #1;
        chk("rst_comb_seg", seg_s, OFF32);
        chk("rst_comb_scan_en", {28'h0, scan_en_m}, 32'hF);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 26; k++) begin
            tick();
            if (k == 0) load = 1'b0;
            chk($sformatf("scan_en_%0d", k), {28'h0, scan_en_m}, {28'h0, en_tab[k % 16]});
            chk($sformatf("scan_seg_%0d", k), {24'h0, scan_seg_m},
                (k == 0) ? 32'hC0 : {24'h0, sseg_tab[k % 16]});
            if (k == 5) chk("mux_seg_off", seg_m, OFF32);
        end

        // now at prescaler 2, digit 2
        reset = 1'b1;
        #1;
        chk("midscan_rst_en", {28'h0, scan_en_m}, 32'hF);
        chk("midscan_rst_seg", {24'h0, scan_seg_m}, 32'hFF);
        tick(); tick();
        chk("midscan_rst_hold_en", {28'h0, scan_en_m}, 32'hF);
        chk("midscan_rst_hold_mseg", seg_m, OFF32);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("restart_en_%0d", k), {28'h0, scan_en_m},
                (k == 3) ? 32'hF : (k == 4) ? 32'hD : 32'hE);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
